// File: rtl/axi4_mem_pkg.sv
// Shared encodings and state enums for the AXI4 SRAM slave and its helpers.
package axi4_mem_pkg;

    localparam int unsigned ADDR_W  = 32;
    localparam int unsigned LEN_W   = 8;
    localparam int unsigned SIZE_W  = 3;
    localparam int unsigned BURST_W = 2;
    localparam int unsigned RESP_W  = 2;

    typedef enum logic [BURST_W-1:0] {
        BURST_FIXED = 2'b00,
        BURST_INCR  = 2'b01,
        BURST_WRAP  = 2'b10
    } burst_e;

    localparam logic [RESP_W-1:0] RESP_OKAY   = 2'b00;
    localparam logic [RESP_W-1:0] RESP_SLVERR = 2'b10;

    typedef enum logic [1:0] {
        W_IDLE,
        W_DATA,
        W_RESP
    } w_state_e;

    typedef enum logic {
        R_IDLE,
        R_DATA
    } r_state_e;

    // WRAP bursts are only defined for 2, 4, 8 or 16 beats.
    function automatic logic wrap_len_ok(input logic [LEN_W-1:0] len);
        return (len == 8'd1) || (len == 8'd3) || (len == 8'd7) || (len == 8'd15);
    endfunction

endpackage

// File: rtl/axi4_burst_addr.sv
// Combinational AXI4 next-beat address generator and burst legality check.
module axi4_burst_addr
    import axi4_mem_pkg::*;
#(
    parameter int unsigned DATA_W = 64
) (
    input  logic [31:0] addr,
    input  logic [7:0]  len,
    input  logic [2:0]  size,
    input  logic [1:0]  burst,
    output logic [31:0] next_addr,
    output logic        illegal
);

    localparam int unsigned LSB = $clog2(DATA_W / 8);

    logic [31:0] incr;
    logic [31:0] incr_addr;
    logic [31:0] wrap_bytes;
    logic [31:0] wrap_mask;
    logic        unaligned;

    always_comb begin
        incr       = 32'(1) << size;
        incr_addr  = addr + incr;
        wrap_bytes = (32'(len) + 32'd1) << size;
        wrap_mask  = wrap_bytes - 32'd1;
        unaligned  = (addr & (incr - 32'd1)) != 32'd0;

        next_addr = addr;
        case (burst)
            BURST_FIXED: next_addr = addr;
            BURST_INCR:  next_addr = incr_addr;
            // Keep the bits above the window, step only inside it.
            BURST_WRAP:  next_addr = (addr & ~wrap_mask) | (incr_addr & wrap_mask);
            default:     next_addr = addr;
        endcase

        illegal = (burst == 2'b11) || (size > 3'(LSB));
        if (burst == BURST_WRAP && (!wrap_len_ok(len) || unaligned)) begin
            illegal = 1'b1;
        end
    end

endmodule

// File: rtl/axi4_sram_slave.sv
// AXI4 slave over an on-chip register array with independent read and write engines.
module axi4_sram_slave
    import axi4_mem_pkg::*;
#(
    parameter int unsigned DATA_W    = 64,
    parameter int unsigned ID_W      = 4,
    parameter int unsigned DEPTH     = 1024,
    parameter logic [31:0] BASE_ADDR = 32'h8000_0000
) (
    input  logic                clock,
    input  logic                reset,

    output logic                io_slave_awready,
    input  logic                io_slave_awvalid,
    input  logic [31:0]         io_slave_awaddr,
    input  logic [ID_W-1:0]     io_slave_awid,
    input  logic [7:0]          io_slave_awlen,
    input  logic [2:0]          io_slave_awsize,
    input  logic [1:0]          io_slave_awburst,

    output logic                io_slave_wready,
    input  logic                io_slave_wvalid,
    input  logic [DATA_W-1:0]   io_slave_wdata,
    input  logic [DATA_W/8-1:0] io_slave_wstrb,
    input  logic                io_slave_wlast,

    input  logic                io_slave_bready,
    output logic                io_slave_bvalid,
    output logic [1:0]          io_slave_bresp,
    output logic [ID_W-1:0]     io_slave_bid,

    output logic                io_slave_arready,
    input  logic                io_slave_arvalid,
    input  logic [31:0]         io_slave_araddr,
    input  logic [ID_W-1:0]     io_slave_arid,
    input  logic [7:0]          io_slave_arlen,
    input  logic [2:0]          io_slave_arsize,
    input  logic [1:0]          io_slave_arburst,

    input  logic                io_slave_rready,
    output logic                io_slave_rvalid,
    output logic [1:0]          io_slave_rresp,
    output logic [DATA_W-1:0]   io_slave_rdata,
    output logic                io_slave_rlast,
    output logic [ID_W-1:0]     io_slave_rid
);

    localparam int unsigned STRB_W    = DATA_W / 8;
    localparam int unsigned LSB       = $clog2(STRB_W);
    localparam int unsigned IDX_W     = $clog2(DEPTH);
    localparam logic [32:0] MEM_BYTES = 33'(DEPTH) * 33'(STRB_W);

    logic [DATA_W-1:0] mem [DEPTH];

    // ---------------------------------------------------------------- write
    w_state_e          w_state;
    w_state_e          w_state_nxt;
    logic [ID_W-1:0]   w_id;
    logic [31:0]       w_addr;
    logic [7:0]        w_len;
    logic [7:0]        w_cnt;
    logic [2:0]        w_size;
    logic [1:0]        w_burst;
    logic              w_err;

    logic [31:0]       w_next_addr;
    logic              w_illegal;
    logic [31:0]       w_off;
    logic              w_in_range;
    logic [IDX_W-1:0]  w_idx;
    logic              w_last_beat;
    logic              w_beat_ok;
    logic              w_beat_err;
    logic              aw_hs;
    logic              w_hs;
    logic              b_hs;
    logic              mem_we;

    axi4_burst_addr #(.DATA_W(DATA_W)) u_w_addr (
        .addr      (w_addr),
        .len       (w_len),
        .size      (w_size),
        .burst     (w_burst),
        .next_addr (w_next_addr),
        .illegal   (w_illegal)
    );

    assign aw_hs       = io_slave_awvalid && io_slave_awready;
    assign w_hs        = io_slave_wvalid && io_slave_wready;
    assign b_hs        = io_slave_bvalid && io_slave_bready;
    assign w_off       = w_addr - BASE_ADDR;
    assign w_in_range  = {1'b0, w_off} < MEM_BYTES;
    assign w_idx       = w_off[LSB +: IDX_W];
    assign w_last_beat = (w_cnt == w_len);
    assign w_beat_ok   = !w_illegal && w_in_range;
    assign mem_we      = w_hs && w_beat_ok;
    assign w_beat_err  = !w_beat_ok || (io_slave_wlast != w_last_beat);

    always_comb begin
        w_state_nxt = w_state;
        case (w_state)
            W_IDLE:  if (aw_hs) w_state_nxt = W_DATA;
            W_DATA:  if (w_hs && w_last_beat) w_state_nxt = W_RESP;
            W_RESP:  if (b_hs) w_state_nxt = W_IDLE;
            default: w_state_nxt = W_IDLE;
        endcase
    end

    // Handshake flags are registered copies of the next state.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            w_state          <= W_IDLE;
            io_slave_awready <= 1'b1;
            io_slave_wready  <= 1'b0;
            io_slave_bvalid  <= 1'b0;
        end else begin
            w_state          <= w_state_nxt;
            io_slave_awready <= (w_state_nxt == W_IDLE);
            io_slave_wready  <= (w_state_nxt == W_DATA);
            io_slave_bvalid  <= (w_state_nxt == W_RESP);
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            w_id           <= '0;
            w_addr         <= '0;
            w_len          <= '0;
            w_cnt          <= '0;
            w_size         <= '0;
            w_burst        <= '0;
            w_err          <= 1'b0;
            io_slave_bid   <= '0;
            io_slave_bresp <= RESP_OKAY;
        end else begin
            if (aw_hs) begin
                w_id    <= io_slave_awid;
                w_addr  <= io_slave_awaddr;
                w_len   <= io_slave_awlen;
                w_size  <= io_slave_awsize;
                w_burst <= io_slave_awburst;
                w_cnt   <= '0;
                w_err   <= 1'b0;
            end
            if (w_hs) begin
                w_addr <= w_next_addr;
                w_cnt  <= w_cnt + 8'd1;
                if (w_beat_err) w_err <= 1'b1;
                if (w_last_beat) begin
                    io_slave_bid   <= w_id;
                    io_slave_bresp <= (w_err || w_beat_err) ? RESP_SLVERR : RESP_OKAY;
                end
            end
        end
    end

    // Memory array is intentionally not reset.
    always_ff @(posedge clock) begin
        if (mem_we) begin
            for (int unsigned b = 0; b < STRB_W; b++) begin
                if (io_slave_wstrb[b]) mem[w_idx][b*8 +: 8] <= io_slave_wdata[b*8 +: 8];
            end
        end
    end

    // ----------------------------------------------------------------- read
    r_state_e          r_state;
    r_state_e          r_state_nxt;
    logic [31:0]       r_addr;
    logic [7:0]        r_len;
    logic [7:0]        r_cnt;
    logic [2:0]        r_size;
    logic [1:0]        r_burst;

    logic [31:0]       rd_cmd_addr;
    logic [7:0]        rd_cmd_len;
    logic [2:0]        rd_cmd_size;
    logic [1:0]        rd_cmd_burst;
    logic [31:0]       rd_next_addr;
    logic              rd_illegal;
    logic [31:0]       rd_load_addr;
    logic [31:0]       rd_off;
    logic              rd_in_range;
    logic [IDX_W-1:0]  rd_idx;
    logic              rd_beat_ok;
    logic [DATA_W-1:0] rd_word;
    logic              ar_hs;
    logic              r_hs;
    logic              r_last_beat;
    logic              r_idle;

    // In idle the checker looks at the incoming AR command, afterwards at the latched one.
    assign r_idle       = (r_state == R_IDLE);
    assign rd_cmd_addr  = r_idle ? io_slave_araddr  : r_addr;
    assign rd_cmd_len   = r_idle ? io_slave_arlen   : r_len;
    assign rd_cmd_size  = r_idle ? io_slave_arsize  : r_size;
    assign rd_cmd_burst = r_idle ? io_slave_arburst : r_burst;

    axi4_burst_addr #(.DATA_W(DATA_W)) u_r_addr (
        .addr      (rd_cmd_addr),
        .len       (rd_cmd_len),
        .size      (rd_cmd_size),
        .burst     (rd_cmd_burst),
        .next_addr (rd_next_addr),
        .illegal   (rd_illegal)
    );

    assign ar_hs        = io_slave_arvalid && io_slave_arready;
    assign r_hs         = io_slave_rvalid && io_slave_rready;
    assign r_last_beat  = (r_cnt == r_len);
    assign rd_load_addr = r_idle ? io_slave_araddr : rd_next_addr;
    assign rd_off       = rd_load_addr - BASE_ADDR;
    assign rd_in_range  = {1'b0, rd_off} < MEM_BYTES;
    assign rd_idx       = rd_off[LSB +: IDX_W];
    assign rd_beat_ok   = !rd_illegal && rd_in_range;
    assign rd_word      = mem[rd_idx];

    always_comb begin
        r_state_nxt = r_state;
        case (r_state)
            R_IDLE:  if (ar_hs) r_state_nxt = R_DATA;
            R_DATA:  if (r_hs && r_last_beat) r_state_nxt = R_IDLE;
            default: r_state_nxt = R_IDLE;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state          <= R_IDLE;
            io_slave_arready <= 1'b1;
            io_slave_rvalid  <= 1'b0;
        end else begin
            r_state          <= r_state_nxt;
            io_slave_arready <= (r_state_nxt == R_IDLE);
            io_slave_rvalid  <= (r_state_nxt == R_DATA);
        end
    end

    // Read data is registered; a same-cycle write to the word lands after this sample.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_addr         <= '0;
            r_len          <= '0;
            r_cnt          <= '0;
            r_size         <= '0;
            r_burst        <= '0;
            io_slave_rid   <= '0;
            io_slave_rdata <= '0;
            io_slave_rresp <= RESP_OKAY;
            io_slave_rlast <= 1'b0;
        end else if (ar_hs) begin
            r_addr         <= io_slave_araddr;
            r_len          <= io_slave_arlen;
            r_size         <= io_slave_arsize;
            r_burst        <= io_slave_arburst;
            r_cnt          <= '0;
            io_slave_rid   <= io_slave_arid;
            io_slave_rdata <= rd_beat_ok ? rd_word : '0;
            io_slave_rresp <= rd_beat_ok ? RESP_OKAY : RESP_SLVERR;
            io_slave_rlast <= (io_slave_arlen == 8'd0);
        end else if (r_hs) begin
            if (r_last_beat) begin
                io_slave_rlast <= 1'b0;
            end else begin
                r_addr         <= rd_next_addr;
                r_cnt          <= r_cnt + 8'd1;
                io_slave_rdata <= rd_beat_ok ? rd_word : '0;
                io_slave_rresp <= rd_beat_ok ? RESP_OKAY : RESP_SLVERR;
                io_slave_rlast <= ((r_cnt + 8'd1) == r_len);
            end
        end
    end

endmodule

// File: tb/tb_axi4_sram_slave.sv
// Self-checking bench for axi4_sram_slave: vector table plus scoreboarded burst sequences.
module tb_axi4_sram_slave;

    logic        clock;
    logic        reset;
    logic        awready, awvalid;
    logic [31:0] awaddr;
    logic [3:0]  awid;
    logic [7:0]  awlen;
    logic [2:0]  awsize;
    logic [1:0]  awburst;
    logic        wready, wvalid;
    logic [63:0] wdata;
    logic [7:0]  wstrb;
    logic        wlast;
    logic        bready, bvalid;
    logic [1:0]  bresp;
    logic [3:0]  bid;
    logic        arready, arvalid;
    logic [31:0] araddr;
    logic [3:0]  arid;
    logic [7:0]  arlen;
    logic [2:0]  arsize;
    logic [1:0]  arburst;
    logic        rready, rvalid;
    logic [1:0]  rresp;
    logic [63:0] rdata;
    logic        rlast;
    logic [3:0]  rid;

    axi4_sram_slave dut (
        .clock            (clock),
        .reset            (reset),
        .io_slave_awready (awready),
        .io_slave_awvalid (awvalid),
        .io_slave_awaddr  (awaddr),
        .io_slave_awid    (awid),
        .io_slave_awlen   (awlen),
        .io_slave_awsize  (awsize),
        .io_slave_awburst (awburst),
        .io_slave_wready  (wready),
        .io_slave_wvalid  (wvalid),
        .io_slave_wdata   (wdata),
        .io_slave_wstrb   (wstrb),
        .io_slave_wlast   (wlast),
        .io_slave_bready  (bready),
        .io_slave_bvalid  (bvalid),
        .io_slave_bresp   (bresp),
        .io_slave_bid     (bid),
        .io_slave_arready (arready),
        .io_slave_arvalid (arvalid),
        .io_slave_araddr  (araddr),
        .io_slave_arid    (arid),
        .io_slave_arlen   (arlen),
        .io_slave_arsize  (arsize),
        .io_slave_arburst (arburst),
        .io_slave_rready  (rready),
        .io_slave_rvalid  (rvalid),
        .io_slave_rresp   (rresp),
        .io_slave_rdata   (rdata),
        .io_slave_rlast   (rlast),
        .io_slave_rid     (rid)
    );

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    typedef struct {
        logic [63:0] data;
        logic [1:0]  resp;
        logic        last;
    } rbeat_t;

    typedef struct {
        logic        wr;
        logic [31:0] addr;
        logic [7:0]  len;
        logic [2:0]  size;
        logic [1:0]  burst;
        logic [63:0] data;
        logic [7:0]  strb;
        logic [63:0] exp_data;
        logic [1:0]  exp_resp;
    } vec_t;

    rbeat_t      r_q[$];
    logic [1:0]  b_q[$];
    logic [63:0] wbeats[16];
    logic [7:0]  wstrbs[16];
    vec_t        vecs[14];
    int          checks = 0;
    int          errors = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic void push_beat(input logic [63:0] d, input logic [1:0] r, input logic l);
        rbeat_t e;
        e.data = d;
        e.resp = r;
        e.last = l;
        r_q.push_back(e);
    endfunction

    task automatic do_write(input logic [31:0] addr, input logic [7:0] len, input logic [2:0] size,
                            input logic [1:0] burst, input logic [3:0] id, input int bad_last,
                            input logic [1:0] exp_resp);
        int   t;
        logic hs;
        logic [1:0] e;
        b_q.push_back(exp_resp);
        awvalid = 1'b1; awaddr = addr; awlen = len; awsize = size; awburst = burst; awid = id;
        t = 0; hs = 1'b0;
        while (!hs && t < 200) begin hs = awready; @(posedge clock); #1; t++; end
        awvalid = 1'b0;
        chk("aw_handshake", 64'(hs), 64'(1));
        chk("wready_latency", 64'(wready), 64'(1));
        for (int i = 0; i <= int'(len); i++) begin
            wvalid = 1'b1; wdata = wbeats[i]; wstrb = wstrbs[i];
            wlast  = (i == int'(len)) ^ (i == bad_last);
            t = 0; hs = 1'b0;
            while (!hs && t < 200) begin hs = wready; @(posedge clock); #1; t++; end
            if (!hs) chk("w_handshake_timeout", 64'(0), 64'(1));
        end
        wvalid = 1'b0; wlast = 1'b0;
        chk("bvalid_latency", 64'(bvalid), 64'(1));
        bready = 1'b1;
        t = 0; hs = 1'b0;
        while (!hs && t < 200) begin
            hs = bvalid;
            if (hs) begin
                e = b_q.pop_front();
                chk("bresp", 64'(bresp), 64'(e));
                chk("bid", 64'(bid), 64'(id));
            end
            @(posedge clock); #1; t++;
        end
        bready = 1'b0;
        chk("b_handshake", 64'(hs), 64'(1));
        chk("awready_after_b", 64'(awready), 64'(1));
    endtask

    task automatic do_read(input logic [31:0] addr, input logic [7:0] len, input logic [2:0] size,
                           input logic [1:0] burst, input logic [3:0] id, input logic toggle);
        int          t;
        int          got;
        logic        hs;
        logic        held_v;
        logic [63:0] held;
        rbeat_t      e;
        arvalid = 1'b1; araddr = addr; arlen = len; arsize = size; arburst = burst; arid = id;
        t = 0; hs = 1'b0;
        while (!hs && t < 200) begin hs = arready; @(posedge clock); #1; t++; end
        arvalid = 1'b0;
        chk("ar_handshake", 64'(hs), 64'(1));
        chk("rvalid_latency", 64'(rvalid), 64'(1));
        got = 0; t = 0; held_v = 1'b0; held = '0;
        while (got <= int'(len) && t < 400) begin
            rready = toggle ? (t % 2 == 1) : 1'b1;
            if (held_v) chk("rdata_hold", rdata, held);
            held_v = 1'b0;
            if (rvalid && rready) begin
                if (r_q.size() == 0) begin
                    chk("r_unexpected_beat", 64'(0), 64'(1));
                end else begin
                    e = r_q.pop_front();
                    chk("rdata", rdata, e.data);
                    chk("rresp", 64'(rresp), 64'(e.resp));
                    chk("rlast", 64'(rlast), 64'(e.last));
                    chk("rid", 64'(rid), 64'(id));
                end
                got++;
            end else if (rvalid) begin
                held   = rdata;
                held_v = 1'b1;
            end
            @(posedge clock); #1; t++;
        end
        rready = 1'b0;
        chk("r_beat_count", 64'(got), 64'(int'(len) + 1));
        chk("arready_after_r", 64'(arready), 64'(1));
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog expired: got timeout expected completion");
        $fatal(1);
    end

    initial begin
        logic hs;
        int   t;

        vecs[0]  = '{1'b1, 32'h8000_0040, 8'd0, 3'd3, 2'b01, 64'h0,                  8'hFF, 64'h0,                  2'b00};
        vecs[1]  = '{1'b1, 32'h8000_0040, 8'd0, 3'd3, 2'b01, 64'hFFFF_FFFF_FFFF_FFFF, 8'h0F, 64'h0,                  2'b00};
        vecs[2]  = '{1'b0, 32'h8000_0040, 8'd0, 3'd3, 2'b01, 64'h0,                  8'h00, 64'h0000_0000_FFFF_FFFF, 2'b00};
        vecs[3]  = '{1'b0, 32'h8000_2000, 8'd0, 3'd3, 2'b01, 64'h0,                  8'h00, 64'h0,                  2'b10};
        vecs[4]  = '{1'b1, 32'h8000_2000, 8'd0, 3'd3, 2'b01, 64'h1111,               8'hFF, 64'h0,                  2'b10};
        vecs[5]  = '{1'b0, 32'h7FFF_FFF8, 8'd0, 3'd3, 2'b01, 64'h0,                  8'h00, 64'h0,                  2'b10};
        vecs[6]  = '{1'b1, 32'h8000_0048, 8'd0, 3'd3, 2'b01, 64'h1234,               8'hFF, 64'h0,                  2'b00};
        vecs[7]  = '{1'b1, 32'h8000_0048, 8'd0, 3'd3, 2'b11, 64'hDEAD,               8'hFF, 64'h0,                  2'b10};
        vecs[8]  = '{1'b0, 32'h8000_0048, 8'd0, 3'd3, 2'b01, 64'h0,                  8'h00, 64'h1234,               2'b00};
        vecs[9]  = '{1'b0, 32'h8000_0048, 8'd0, 3'd4, 2'b01, 64'h0,                  8'h00, 64'h0,                  2'b10};
        vecs[10] = '{1'b1, 32'h8000_1FF8, 8'd0, 3'd3, 2'b01, 64'h5A5A,               8'hFF, 64'h0,                  2'b00};
        vecs[11] = '{1'b0, 32'h8000_1FF8, 8'd0, 3'd3, 2'b01, 64'h0,                  8'h00, 64'h5A5A,               2'b00};
        vecs[12] = '{1'b0, 32'h8000_0000, 8'd2, 3'd3, 2'b10, 64'h0,                  8'h00, 64'h0,                  2'b10};
        vecs[13] = '{1'b0, 32'h8000_0004, 8'd1, 3'd3, 2'b10, 64'h0,                  8'h00, 64'h0,                  2'b10};

        reset = 1'b0;
        awvalid = 1'b0; awaddr = '0; awid = '0; awlen = '0; awsize = '0; awburst = '0;
        wvalid = 1'b0; wdata = '0; wstrb = '0; wlast = 1'b0; bready = 1'b0;
        arvalid = 1'b0; araddr = '0; arid = '0; arlen = '0; arsize = '0; arburst = '0;
        rready = 1'b0;
        #1 reset = 1'b1;
        repeat (3) @(posedge clock);
        #1;
        chk("rst_awready", 64'(awready), 64'(1));
        chk("rst_arready", 64'(arready), 64'(1));
        chk("rst_wready", 64'(wready), 64'(0));
        chk("rst_bvalid", 64'(bvalid), 64'(0));
        chk("rst_rvalid", 64'(rvalid), 64'(0));
        chk("rst_rdata", rdata, 64'(0));
        chk("rst_rlast", 64'(rlast), 64'(0));
        chk("rst_bresp", 64'(bresp), 64'(0));
        chk("rst_rresp", 64'(rresp), 64'(0));
        chk("rst_bid", 64'(bid), 64'(0));
        chk("rst_rid", 64'(rid), 64'(0));
        reset = 1'b0;
        @(posedge clock); #1;

        // INCR write of 1..4 then matching read.
        for (int i = 0; i < 4; i++) begin wbeats[i] = 64'(i + 1); wstrbs[i] = 8'hFF; end
        do_write(32'h8000_0000, 8'd3, 3'd3, 2'b01, 4'd3, -1, 2'b00);
        for (int i = 0; i < 4; i++) push_beat(64'(i + 1), 2'b00, i == 3);
        do_read(32'h8000_0000, 8'd3, 3'd3, 2'b01, 4'd9, 1'b0);

        // WRAP read starting at word 2 of a 4-word window.
        push_beat(64'd3, 2'b00, 1'b0);
        push_beat(64'd4, 2'b00, 1'b0);
        push_beat(64'd1, 2'b00, 1'b0);
        push_beat(64'd2, 2'b00, 1'b1);
        do_read(32'h8000_0010, 8'd3, 3'd3, 2'b10, 4'd2, 1'b0);

        for (int v = 0; v < 14; v++) begin
            if (vecs[v].wr) begin
                for (int i = 0; i <= int'(vecs[v].len); i++) begin
                    wbeats[i] = vecs[v].data;
                    wstrbs[i] = vecs[v].strb;
                end
                do_write(vecs[v].addr, vecs[v].len, vecs[v].size, vecs[v].burst, 4'(v), -1, vecs[v].exp_resp);
            end else begin
                for (int i = 0; i <= int'(vecs[v].len); i++)
                    push_beat(vecs[v].exp_data, vecs[v].exp_resp, i == int'(vecs[v].len));
                do_read(vecs[v].addr, vecs[v].len, vecs[v].size, vecs[v].burst, 4'(v), 1'b0);
            end
        end

        // wlast on beat 0 of a 2-beat write.
        wbeats[0] = 64'h10; wbeats[1] = 64'h11; wstrbs[0] = 8'hFF; wstrbs[1] = 8'hFF;
        do_write(32'h8000_0080, 8'd1, 3'd3, 2'b01, 4'd7, 0, 2'b10);

        // FIXED burst: both beats hit the same word.
        wbeats[0] = 64'd7; wbeats[1] = 64'd8;
        do_write(32'h8000_0300, 8'd1, 3'd3, 2'b00, 4'd1, -1, 2'b00);
        push_beat(64'd8, 2'b00, 1'b1);
        do_read(32'h8000_0300, 8'd0, 3'd3, 2'b01, 4'd1, 1'b0);

        // 8-beat read with rready toggling, concurrent with a 4-beat write elsewhere.
        for (int i = 0; i < 8; i++) begin wbeats[i] = 64'hA0 + 64'(i); wstrbs[i] = 8'hFF; end
        do_write(32'h8000_0100, 8'd7, 3'd3, 2'b01, 4'd4, -1, 2'b00);
        for (int i = 0; i < 8; i++) push_beat(64'hA0 + 64'(i), 2'b00, i == 7);
        for (int i = 0; i < 4; i++) wbeats[i] = 64'hB0 + 64'(i);
        fork
            do_read(32'h8000_0100, 8'd7, 3'd3, 2'b01, 4'd5, 1'b1);
            do_write(32'h8000_0200, 8'd3, 3'd3, 2'b01, 4'd6, -1, 2'b00);
        join
        for (int i = 0; i < 4; i++) push_beat(64'hB0 + 64'(i), 2'b00, i == 3);
        do_read(32'h8000_0200, 8'd3, 3'd3, 2'b01, 4'd6, 1'b0);

        // Reset during beat 2 of a 4-beat write.
        wbeats[0] = 64'h0BAD; wbeats[1] = 64'h0BAD;
        do_write(32'h8000_0410, 8'd1, 3'd3, 2'b01, 4'd5, -1, 2'b00);
        for (int i = 0; i < 4; i++) wbeats[i] = 64'hC0 + 64'(i);
        awvalid = 1'b1; awaddr = 32'h8000_0400; awlen = 8'd3; awsize = 3'd3; awburst = 2'b01; awid = 4'd6;
        t = 0; hs = 1'b0;
        while (!hs && t < 200) begin hs = awready; @(posedge clock); #1; t++; end
        awvalid = 1'b0;
        chk("rst_test_aw", 64'(hs), 64'(1));
        for (int i = 0; i < 2; i++) begin
            wvalid = 1'b1; wdata = wbeats[i]; wstrb = 8'hFF; wlast = 1'b0;
            t = 0; hs = 1'b0;
            while (!hs && t < 200) begin hs = wready; @(posedge clock); #1; t++; end
            if (!hs) chk("rst_test_w_timeout", 64'(0), 64'(1));
        end
        wvalid = 1'b1; wdata = wbeats[2];
        #2 reset = 1'b1;
        #1;
        chk("midrst_awready", 64'(awready), 64'(1));
        chk("midrst_wready", 64'(wready), 64'(0));
        chk("midrst_bvalid", 64'(bvalid), 64'(0));
        chk("midrst_arready", 64'(arready), 64'(1));
        chk("midrst_rvalid", 64'(rvalid), 64'(0));
        chk("midrst_rdata", rdata, 64'(0));
        chk("midrst_bid", 64'(bid), 64'(0));
        wvalid = 1'b0;
        @(posedge clock); #1;
        reset = 1'b0;
        @(posedge clock); #1;
        wbeats[0] = 64'h77; wstrbs[0] = 8'hFF;
        do_write(32'h8000_0500, 8'd0, 3'd3, 2'b01, 4'd2, -1, 2'b00);
        push_beat(64'hC0, 2'b00, 1'b0);
        push_beat(64'hC1, 2'b00, 1'b0);
        push_beat(64'h0BAD, 2'b00, 1'b0);
        push_beat(64'h0BAD, 2'b00, 1'b1);
        do_read(32'h8000_0400, 8'd3, 3'd3, 2'b01, 4'd3, 1'b0);
        push_beat(64'h77, 2'b00, 1'b1);
        do_read(32'h8000_0500, 8'd0, 3'd3, 2'b01, 4'd3, 1'b0);

        chk("r_queue_drained", 64'(r_q.size()), 64'(0));
        chk("b_queue_drained", 64'(b_q.size()), 64'(0));
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
